// File: rtl/pll_clken_gen.sv
// Lock qualifier plus NUM_CLOCKS programmable divided clock-enable streams on the PLL clock.
// Build option PLL_CLKEN_ALIGN_EN: any cfg write realigns every channel to its phase offset.
module pll_clken_gen #(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int RESET_DIV   = 1,
    localparam int CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic                  locked,
    output logic [NUM_CLOCKS-1:0] clken
);

    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(RESET_DIV);

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, RUN} state_t;

    state_t          state;
    logic            sync1;
    logic            lk_s;
    logic [LW-1:0]   lock_cnt;
    logic            enter_run;
    logic [DIV_W-1:0] div_s   [NUM_CLOCKS];
    logic [DIV_W-1:0] phase_s [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt     [NUM_CLOCKS];

    function automatic logic [DIV_W-1:0] start_cnt(input logic [DIV_W-1:0] phase,
                                                   input logic [DIV_W-1:0] div);
        return (phase < div) ? phase : div;
    endfunction

    // The WAIT_LOCK cycle that first sees lk_s counts as the first stable cycle.
    always_comb begin
        enter_run = 1'b0;
        if (lk_s) begin
            if (state == WAIT_LOCK)
                enter_run = (LOCK_CYCLES <= 1);
            else if (state == COUNT)
                enter_run = (lock_cnt == LOCK_LAST);
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            lk_s     <= 1'b0;
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk_s  <= sync1;
            if (enter_run) begin
                state    <= RUN;
                locked   <= 1'b1;
                lock_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        lock_cnt <= '0;
                        if (lk_s) begin
                            state    <= COUNT;
                            lock_cnt <= LW'(1);
                        end
                    end
                    COUNT: begin
                        if (!lk_s) begin
                            state    <= WAIT_LOCK;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LW'(1);
                        end
                    end
                    RUN: begin
                        if (!lk_s) begin
                            state  <= WAIT_LOCK;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= WAIT_LOCK;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PLL_CLKEN_ALIGN_EN
    logic realign;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst)
            realign <= 1'b0;
        else
            realign <= cfg_we && (int'(cfg_ch) < NUM_CLOCKS);
    end
`endif

    // Reloads only ever happen at a wrap, RUN entry or realign, so the shadow
    // registers double as the active div/phase without a separate copy.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                div_s[i]   <= DIV_RST;
                phase_s[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    div_s[i]   <= cfg_div;
                    phase_s[i] <= cfg_phase;
                end
                if (enter_run)
                    cnt[i] <= start_cnt(phase_s[i], div_s[i]);
`ifdef PLL_CLKEN_ALIGN_EN
                else if (realign)
                    cnt[i] <= start_cnt(phase_s[i], div_s[i]);
`endif
                else if (locked)
                    cnt[i] <= (cnt[i] == '0) ? div_s[i] : cnt[i] - DIV_W'(1);
            end
        end
    end

    always_comb begin
        clken = '0;
        for (int unsigned i = 0; i < NUM_CLOCKS; i++)
            clken[i] = locked && (cnt[i] == '0);
    end

endmodule

// File: doc/pll_clken_gen.md
# pll_clken_gen

Parametrised clock-enable generator that sits directly behind the FPGA PLL wrapper. It qualifies the PLL `locked` flag with a synchroniser and stability counter, then derives NUM_CLOCKS independent divided clock-enable streams on the single PLL output clock. Each stream has a run-time programmable divide ratio and phase. Downstream logic uses one global clock plus these enables instead of consuming extra PLL outputs.

## Interface
Parameters:
- NUM_CLOCKS, 4, number of enable channels (1..16)
- DIV_W, 16, width of divide/phase fields
- LOCK_CYCLES, 1024, consecutive synchronised-high cycles of `pll_locked` required before `locked` asserts (≥1)
- RESET_DIV, 1, divide field loaded at reset for every channel

Ports:
- refclk  in  1  sole clock (PLL output clock); all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-low
- pll_locked  in  1  raw PLL lock flag, asynchronous to refclk
- cfg_we  in  1  single-cycle configuration write strobe
- cfg_ch  in  $clog2(NUM_CLOCKS) (min 1)  target channel
- cfg_div  in  DIV_W  divide field; period = cfg_div+1 cycles
- cfg_phase  in  DIV_W  phase offset in cycles
- locked  out  1  qualified lock
- clken  out  NUM_CLOCKS  per-channel one-cycle enable pulses

## Operation
- Reset (`rst` = 0): sync flops, lock counter and all channel counters are cleared; shadow and active div are set to RESET_DIV and phase to 0; FSM enters WAIT_LOCK. Outputs: `locked` = 0, `clken` = 0.
- `pll_locked` passes through a 2-flop synchroniser to produce `lk_s`.
- FSM:
  - WAIT_LOCK: lock counter = 0. When `lk_s` = 1, go to COUNT.
  - COUNT: lock counter increments each cycle `lk_s` = 1. If `lk_s` = 0, return to WAIT_LOCK. When the counter reaches LOCK_CYCLES-1 with `lk_s` = 1, go to RUN and load every channel counter with min(phase, div).
  - RUN: `locked` = 1. If `lk_s` = 0, go to WAIT_LOCK; `locked` and all `clken` drop in the same cycle the FSM leaves RUN.
- Channel i in RUN: `cnt[i]` counts down. `clken[i]` = 1 exactly in cycles where `cnt[i]` = 0, after which `cnt[i]` reloads with div. div = 0 gives `clken[i]` high every cycle.
- Config write: `cfg_we` latches cfg_div/cfg_phase into channel `cfg_ch` shadow registers. Writes are accepted in any FSM state. `cfg_ch` ≥ NUM_CLOCKS is ignored.
- When the shadow registers become active depends on the PLL_CLKEN_ALIGN_EN build option (see Configuration).
- Two writes to the same channel before activation: the last write wins.

## Timing
- Raw `pll_locked` rise to `locked` = 1: 2 + LOCK_CYCLES refclk cycles.
- Raw `pll_locked` fall to `locked` = 0 and `clken` = 0: 3 cycles.
- First `clken[i]` after RUN entry: in cycle min(phase,div) counted from the first `locked` = 1 cycle, inclusive. So phase 0 means `clken[i]` is high in the same cycle `locked` rises.
- `clken` is decoded from registered state only; there is no input-to-output combinational path.
- Async reset mid-RUN: outputs go low immediately. Re-lock then takes the full latency again.

## Configuration
- Macro PLL_CLKEN_ALIGN_EN:
  - Defined: a cfg write marks all channels for realignment. On the cycle after the write, every channel's active div/phase is loaded from its shadow and its counter is reloaded with min(phase, div). The next `clken` of every channel then occurs at its phase offset, giving mutually phase-aligned streams.
  - Undefined: only the written channel changes. Its shadow is copied to active at that channel's next `clken` pulse (the wrap cycle), and the reload uses the new div. Other channels are undisturbed. When not in RUN, the copy happens at RUN entry.

## Test plan
- Reset then `pll_locked` = 1 with LOCK_CYCLES = 8 -> `locked` rises exactly 10 cycles later; all 4 channels at div 1, phase 0 pulse on cycles 0, 2, 4, … relative to lock.
- `pll_locked` glitches low for 1 cycle during COUNT -> counter restarts; `locked` rises 10 cycles after the glitch ends.
- In RUN, write ch2 div = 4, phase = 2 (align off) -> ch2 keeps its old period until its next pulse, then pulses every 5 cycles; ch0, ch1, ch3 periods are unchanged.
- Same write with PLL_CLKEN_ALIGN_EN defined -> all channels reload the cycle after the write; ch2 first pulses 2 cycles later; channels with phase 0 pulse immediately.
- Drop `pll_locked` in RUN -> `locked` and `clken` = 0 exactly 3 cycles later; on re-lock, phases restart from the shadow values.
- Assert `rst` = 0 mid-RUN -> outputs are 0 asynchronously; after release, div returns to RESET_DIV.
